// File: rtl/vx_gpu_pkg.sv
// Shared warp-control types and widths for the warp control sink slice.
package vx_gpu_pkg;

    localparam int unsigned VX_NUM_WARPS    = 4;
    localparam int unsigned VX_NUM_THREADS  = 4;
    localparam int unsigned VX_NUM_BARRIERS = 4;
    localparam int unsigned VX_XLEN         = 32;
    localparam int unsigned VX_NW_WIDTH     = (VX_NUM_WARPS > 1) ? $clog2(VX_NUM_WARPS) : 1;
    // One spare bit so out-of-range barrier ids can be presented and rejected.
    localparam int unsigned VX_NB_WIDTH     = $clog2(VX_NUM_BARRIERS) + 1;

    typedef struct packed {
        logic                      valid;
        logic [VX_NUM_THREADS-1:0] tmask;
    } tmc_t;

    typedef struct packed {
        logic                    valid;
        logic [VX_NUM_WARPS-1:0] wmask;
        logic [VX_XLEN-1:0]      pc;
    } wspawn_t;

    typedef struct packed {
        logic                   valid;
        logic [VX_NB_WIDTH-1:0] id;
        logic [VX_NW_WIDTH-1:0] size_m1;
    } barrier_t;

endpackage

// File: rtl/vx_warp_ctl_if.sv
// Warp control beat from the execute stage; no back-pressure.
interface vx_warp_ctl_if;
    import vx_gpu_pkg::*;

    logic                   valid;
    logic [VX_NW_WIDTH-1:0] wid;
    tmc_t                   tmc;
    wspawn_t                wspawn;
    barrier_t               barrier;

    modport master (output valid, wid, tmc, wspawn, barrier);
    modport slave  (input  valid, wid, tmc, wspawn, barrier);

endinterface

// File: rtl/vx_barrier_table.sv
// Per-barrier arrival counts and wait masks; reports stall or release for each arrival.
module vx_barrier_table
    import vx_gpu_pkg::*;
#(
    parameter int unsigned NUM_WARPS    = VX_NUM_WARPS,
    parameter int unsigned NUM_BARRIERS = VX_NUM_BARRIERS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arrive_valid,
    input  logic [VX_NB_WIDTH-1:0] arrive_id,
    input  logic [VX_NW_WIDTH-1:0] arrive_wid,
    input  logic [VX_NW_WIDTH-1:0] arrive_size_m1,
    output logic                   arrive_stall,
    output logic                   release_valid,
    output logic [NUM_WARPS-1:0]   release_mask
);

    localparam int unsigned CNT_W = $clog2(NUM_WARPS + 1);
    localparam int unsigned BID_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    logic [CNT_W-1:0]     count_q [NUM_BARRIERS];
    logic [CNT_W-1:0]     count_d [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wait_q  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wait_d  [NUM_BARRIERS];

    logic [BID_W-1:0] idx;
    logic             in_range;
    logic             dup;
    logic             hit;
    logic             full;

    always_comb begin
        idx           = arrive_id[BID_W-1:0];
        in_range      = 32'(arrive_id) < NUM_BARRIERS;
        dup           = wait_q[idx][arrive_wid];
        hit           = arrive_valid && in_range && !dup;
        full          = count_q[idx] == CNT_W'(arrive_size_m1);
        release_valid = hit && full;
        arrive_stall  = hit && !full;
        release_mask  = wait_q[idx];
        release_mask[arrive_wid] = 1'b1;

        count_d = count_q;
        wait_d  = wait_q;
        if (release_valid) begin
            count_d[idx] = '0;
            wait_d[idx]  = '0;
        end else if (arrive_stall) begin
            count_d[idx]             = count_q[idx] + 1'b1;
            wait_d[idx][arrive_wid]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
                count_q[b] <= '0;
                wait_q[b]  <= '0;
            end
        end else begin
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

    dup_arrival_a: assert property (@(posedge clk) disable iff (reset)
        !(arrive_valid && in_range && dup));

endmodule

// File: rtl/vx_warp_ctl_sink.sv
// Warp control sink: applies tmc/wspawn/barrier beats to warp state one cycle later.
// Optional barrier-stall cycle counter enabled by defining WCTL_PERF_EN.
module vx_warp_ctl_sink
    import vx_gpu_pkg::*;
#(
    parameter int unsigned NUM_WARPS    = VX_NUM_WARPS,
    parameter int unsigned NUM_THREADS  = VX_NUM_THREADS,
    parameter int unsigned NUM_BARRIERS = VX_NUM_BARRIERS
) (
    input  logic                                  clk,
    input  logic                                  reset,
    vx_warp_ctl_if.slave                          warp_ctl_if,
    output logic [NUM_WARPS-1:0]                  active_warps,
    output logic [NUM_WARPS-1:0][NUM_THREADS-1:0] thread_masks,
    output logic [NUM_WARPS-1:0]                  stalled_warps,
    output logic [NUM_WARPS-1:0]                  pc_load_mask,
    output logic [VX_XLEN-1:0]                    spawn_pc,
    output logic                                  unlock_valid,
    output logic [VX_NW_WIDTH-1:0]                unlock_wid,
    output logic [63:0]                           perf_bar_stalls
);

    localparam logic [NUM_WARPS-1:0][NUM_THREADS-1:0] MASKS_RST =
        {{(NUM_WARPS*NUM_THREADS-1){1'b0}}, 1'b1};

    logic [NUM_WARPS-1:0]                  active_q, active_d;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0] masks_q, masks_d;
    logic [NUM_WARPS-1:0]                  stalled_q, stalled_d;
    logic [NUM_WARPS-1:0]                  pc_load_q, pc_load_d;
    logic [VX_XLEN-1:0]                    spawn_pc_q, spawn_pc_d;
    logic                                  unlock_valid_q, unlock_valid_d;
    logic [VX_NW_WIDTH-1:0]                unlock_wid_q, unlock_wid_d;

    logic                 bar_stall;
    logic                 bar_release;
    logic [NUM_WARPS-1:0] bar_release_mask;

    vx_barrier_table #(
        .NUM_WARPS    (NUM_WARPS),
        .NUM_BARRIERS (NUM_BARRIERS)
    ) barrier_table (
        .clk            (clk),
        .reset          (reset),
        .arrive_valid   (warp_ctl_if.valid && warp_ctl_if.barrier.valid),
        .arrive_id      (warp_ctl_if.barrier.id),
        .arrive_wid     (warp_ctl_if.wid),
        .arrive_size_m1 (warp_ctl_if.barrier.size_m1),
        .arrive_stall   (bar_stall),
        .release_valid  (bar_release),
        .release_mask   (bar_release_mask)
    );

    // Ordering within one beat: wspawn, then tmc (overrides on wid), then barrier.
    always_comb begin
        active_d       = active_q;
        masks_d        = masks_q;
        stalled_d      = stalled_q;
        pc_load_d      = '0;
        spawn_pc_d     = spawn_pc_q;
        unlock_valid_d = 1'b0;
        unlock_wid_d   = unlock_wid_q;

        if (warp_ctl_if.valid) begin
            unlock_valid_d = 1'b1;
            unlock_wid_d   = warp_ctl_if.wid;

            if (warp_ctl_if.wspawn.valid) begin
                spawn_pc_d = warp_ctl_if.wspawn.pc;
                for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                    if (warp_ctl_if.wspawn.wmask[w] && !active_q[w]) begin
                        active_d[w]  = 1'b1;
                        masks_d[w]   = NUM_THREADS'(1);
                        pc_load_d[w] = 1'b1;
                    end
                end
            end

            if (warp_ctl_if.tmc.valid) begin
                masks_d[warp_ctl_if.wid] = warp_ctl_if.tmc.tmask;
                if (warp_ctl_if.tmc.tmask == '0)
                    active_d[warp_ctl_if.wid] = 1'b0;
            end

            if (bar_release)
                stalled_d = stalled_d & ~bar_release_mask;
            else if (bar_stall)
                stalled_d[warp_ctl_if.wid] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q       <= NUM_WARPS'(1);
            masks_q        <= MASKS_RST;
            stalled_q      <= '0;
            pc_load_q      <= '0;
            spawn_pc_q     <= '0;
            unlock_valid_q <= 1'b0;
            unlock_wid_q   <= '0;
        end else begin
            active_q       <= active_d;
            masks_q        <= masks_d;
            stalled_q      <= stalled_d;
            pc_load_q      <= pc_load_d;
            spawn_pc_q     <= spawn_pc_d;
            unlock_valid_q <= unlock_valid_d;
            unlock_wid_q   <= unlock_wid_d;
        end
    end

`ifdef WCTL_PERF_EN
    logic [63:0] perf_q, perf_d;

    always_comb perf_d = perf_q + 64'(|stalled_q);

    always_ff @(posedge clk) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_bar_stalls = perf_q;
`else
    assign perf_bar_stalls = '0;
`endif

    assign active_warps  = active_q;
    assign thread_masks  = masks_q;
    assign stalled_warps = stalled_q;
    assign pc_load_mask  = pc_load_q;
    assign spawn_pc      = spawn_pc_q;
    assign unlock_valid  = unlock_valid_q;
    assign unlock_wid    = unlock_wid_q;

endmodule
